// File: rtl/force_accum_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : force_accum_cache_pkg
//  Description : Shared types and saturating vector add for the force cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package force_accum_cache_pkg;

    localparam int c_FRC_W = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } cache_state_e;

    typedef logic signed [c_FRC_W-1:0] frc_t;

    // z occupies the most significant bits of a packed entry
    typedef struct packed {
        frc_t z;
        frc_t y;
        frc_t x;
    } frc_vec_t;

    localparam logic signed [c_FRC_W:0] c_SUM_MAX = {2'b00, {(c_FRC_W-1){1'b1}}};
    localparam logic signed [c_FRC_W:0] c_SUM_MIN = {2'b11, {(c_FRC_W-2){1'b0}}, 1'b1};

    function automatic frc_t sat_add(input frc_t a, input frc_t b);
        logic signed [c_FRC_W:0] w_sum;
        w_sum = {a[c_FRC_W-1], a} + {b[c_FRC_W-1], b};
        if (w_sum > c_SUM_MAX)
            return c_SUM_MAX[c_FRC_W-1:0];
        else if (w_sum < c_SUM_MIN)
            return c_SUM_MIN[c_FRC_W-1:0];
        else
            return w_sum[c_FRC_W-1:0];
    endfunction

    function automatic frc_vec_t sat_add_vec(input frc_vec_t a, input frc_vec_t b);
        frc_vec_t w_r;
        w_r.x = sat_add(a.x, b.x);
        w_r.y = sat_add(a.y, b.y);
        w_r.z = sat_add(a.z, b.z);
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/force_accum_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : force_accum_cache_if
//  Description : Force push streams and motion-update read port of the cache.
//  Revision    : 1.0 - initial release
// ============================================================================
interface force_accum_cache_if #(
    parameter int NUM_IN = 4,
    parameter int FRC_W  = 32,
    parameter int ADDR_W = 8
);
    logic [NUM_IN*3*FRC_W-1:0] i_frc;
    logic [NUM_IN*ADDR_W-1:0]  i_frc_parid;
    logic [NUM_IN-1:0]         i_frc_valid;
    logic [NUM_IN-1:0]         o_almost_full;
    logic [ADDR_W-1:0]         i_rd_addr;
    logic                      i_rd_en;
    logic [3*FRC_W-1:0]        o_rd_frc;
    logic                      o_rd_valid;

    modport master (
        output i_frc, i_frc_parid, i_frc_valid, i_rd_addr, i_rd_en,
        input  o_almost_full, o_rd_frc, o_rd_valid
    );

    modport slave (
        input  i_frc, i_frc_parid, i_frc_valid, i_rd_addr, i_rd_en,
        output o_almost_full, o_rd_frc, o_rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/force_accum_cache_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : force_in_fifo
//  Description : Synchronous input FIFO with almost-full and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module force_in_fifo #(
    parameter int DATA_W   = 104,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_pop,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_empty,
    output logic                   o_almost_full,
    output logic                   o_overflow
);
    localparam int             c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]  c_FULL = (c_PW+1)'(DEPTH);
    localparam logic [c_PW:0]  c_AF   = (c_PW+1)'(AF_LEVEL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_PW:0]     r_count;
    logic              r_ovf;
    logic              w_full;
    logic              w_wr;
    logic              w_rd;

    assign w_full = (r_count == c_FULL);
    assign w_wr   = i_push & ~w_full;
    assign w_rd   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + c_PW'(1);
            if (w_rd)
                r_rptr <= r_rptr + c_PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
            // a push against a full FIFO is lost even if a pop frees a slot
            if (i_push & w_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= i_data;
    end

    assign o_data        = r_mem[r_rptr];
    assign o_empty       = (r_count == '0);
    assign o_almost_full = (r_count >= c_AF);
    assign o_overflow    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/force_accum_cache.sv
`default_nettype none
// ============================================================================
//  Module      : force_accum_cache
//  Description : Per-cell force accumulator: NUM_IN FIFOs, RR arbiter, RMW RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module force_accum_cache
    import force_accum_cache_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int FRC_W      = c_FRC_W,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int CLR_ON_RD  = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    force_accum_cache_if.slave     io_bus,
    input  wire logic              i_clr_all,
    output logic                   o_idle,
    output logic                   o_overflow
);
    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam int                c_ENT_W  = 3 * FRC_W;
    localparam int                c_DATA_W = c_ADDR_W + c_ENT_W;
    localparam int                c_PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST = c_ADDR_W'(DEPTH - 1);
    localparam logic              c_CLR    = (CLR_ON_RD != 0);

    cache_state_e          r_state;
    logic [c_ADDR_W-1:0]   r_clr_cnt;
    logic                  r_idle;
    logic [c_PTR_W-1:0]    r_rr_ptr;

    logic [c_DATA_W-1:0]   w_fifo_dout [NUM_IN];
    logic [NUM_IN-1:0]     w_empty;
    logic [NUM_IN-1:0]     w_af;
    logic [NUM_IN-1:0]     w_ovf;
    logic [NUM_IN-1:0]     w_pop;
    logic [NUM_IN-1:0]     w_req;
    logic                  w_run;
    logic                  w_rd_go;
    logic                  w_gnt_vld;
    logic [c_PTR_W-1:0]    w_gnt_idx;
    logic [c_PTR_W-1:0]    w_cand;
    logic [c_DATA_W-1:0]   w_gnt_data;

    logic                  w_s0_vld;
    logic                  w_s0_mu;
    logic [c_ADDR_W-1:0]   w_s0_addr;
    frc_vec_t              w_s0_frc;

    logic                  r_s1_vld;
    logic                  r_s1_mu;
    logic [c_ADDR_W-1:0]   r_s1_addr;
    frc_vec_t              r_s1_frc;
    logic                  r_fwd_vld;
    frc_vec_t              r_fwd_dat;
    frc_vec_t              r_ram_q;
    frc_vec_t              r_mem [DEPTH];

    frc_vec_t              w_s1_old;
    frc_vec_t              w_s1_wdat;
    logic                  w_s1_we;
    logic                  w_ram_we;
    logic [c_ADDR_W-1:0]   w_ram_waddr;
    frc_vec_t              w_ram_wdat;

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
            force_in_fifo #(
                .DATA_W   (c_DATA_W),
                .DEPTH    (FIFO_DEPTH),
                .AF_LEVEL (AF_LEVEL)
            ) u_fifo (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_push        (io_bus.i_frc_valid[g]),
                .i_data        ({io_bus.i_frc_parid[g*c_ADDR_W +: c_ADDR_W],
                                 io_bus.i_frc[g*c_ENT_W +: c_ENT_W]}),
                .i_pop         (w_pop[g]),
                .o_data        (w_fifo_dout[g]),
                .o_empty       (w_empty[g]),
                .o_almost_full (w_af[g]),
                .o_overflow    (w_ovf[g])
            );
        end
    endgenerate

    assign w_run   = (r_state == RUN);
    assign w_rd_go = w_run & io_bus.i_rd_en;
    assign w_req   = (w_run & ~io_bus.i_rd_en) ? ~w_empty : '0;

    // Scan from highest offset down so the port nearest r_rr_ptr wins last
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + i) % NUM_IN);
            if (w_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_pop      = w_gnt_vld ? (NUM_IN'(1) << w_gnt_idx) : '0;
    assign w_gnt_data = w_fifo_dout[w_gnt_idx];

    assign w_s0_vld  = w_rd_go | w_gnt_vld;
    assign w_s0_mu   = w_rd_go;
    assign w_s0_addr = w_rd_go ? io_bus.i_rd_addr : w_gnt_data[c_DATA_W-1 -: c_ADDR_W];
    assign w_s0_frc  = frc_vec_t'(w_gnt_data[c_ENT_W-1:0]);

    assign w_s1_old  = r_fwd_vld ? r_fwd_dat : r_ram_q;
    assign w_s1_we   = r_s1_vld & (~r_s1_mu | c_CLR);
    assign w_s1_wdat = r_s1_mu ? '0 : sat_add_vec(w_s1_old, r_s1_frc);

    // An in-flight S1 write takes the port; the clear counter simply waits
    assign w_ram_we    = w_s1_we | (r_state == CLEAR);
    assign w_ram_waddr = w_s1_we ? r_s1_addr : r_clr_cnt;
    assign w_ram_wdat  = w_s1_we ? w_s1_wdat : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_idle    <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (!w_s1_we) begin
                        if (r_clr_cnt == c_LAST) begin
                            r_state   <= RUN;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + c_ADDR_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (i_clr_all)
                        r_state <= CLEAR;
                end
                default: r_state <= CLEAR;
            endcase
            r_idle <= w_run & ~i_clr_all & (&w_empty) & ~w_s0_vld & ~r_s1_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_mu   <= 1'b0;
            r_s1_addr <= '0;
            r_s1_frc  <= '0;
            r_fwd_vld <= 1'b0;
            r_fwd_dat <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_s1_vld  <= w_s0_vld;
            r_s1_mu   <= w_s0_mu;
            r_s1_addr <= w_s0_addr;
            r_s1_frc  <= w_s0_frc;
            r_fwd_vld <= w_s0_vld & w_s1_we & (r_s1_addr == w_s0_addr);
            r_fwd_dat <= w_s1_wdat;
            if (w_gnt_vld)
                r_rr_ptr <= (w_gnt_idx == c_PTR_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_mem[w_ram_waddr] <= w_ram_wdat;
        r_ram_q <= r_mem[w_s0_addr];
    end

    assign io_bus.o_almost_full = (r_state == CLEAR) ? '1 : w_af;
    assign io_bus.o_rd_valid    = r_s1_vld & r_s1_mu;
    assign io_bus.o_rd_frc      = (r_s1_vld & r_s1_mu) ? w_s1_old : '0;
    assign o_idle               = r_idle;
    assign o_overflow           = |w_ovf;

endmodule
`default_nettype wire
